riscv_wb_stage: RTL and testbench

RISCV_WB_STAGE -- requirements
Module: riscv_wb_stage

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/riscv_wb_stage_if.sv | 33 +++
 rtl/riscv_load_align.sv | 39 +++
 rtl/riscv_wb_stage.sv | 102 ++++++++++
 tb/tb_riscv_wb_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V writeback stage: writeback source select,
// load funct3 codes and the writeback FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        WbAlu  = 2'b00,
        WbMem  = 2'b01,
        WbPc4  = 2'b10,
        WbRsvd = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StCommit
    } wb_state_e;

    // Link address for JAL/JALR; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/riscv_wb_stage_if.sv
// MEM->WB handshake, load response and regfile write-port bundle.
interface riscv_wb_stage_if;

    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rd_i;
    logic        RegWEn_i;
    logic [1:0]  WBSel_i;
    logic [31:0] alu_i;
    logic [31:0] pc_i;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lsb_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  AddrD_o;
    logic [31:0] DataD_o;
    logic        RegWEn_o;
    logic        pending_o;
    logic [4:0]  pending_rd_o;

    modport slave (
        input  valid_i, rd_i, RegWEn_i, WBSel_i, alu_i, pc_i, funct3_i, addr_lsb_i,
               mem_rvalid_i, mem_rdata_i,
        output ready_o, AddrD_o, DataD_o, RegWEn_o, pending_o, pending_rd_o
    );

    modport master (
        output valid_i, rd_i, RegWEn_i, WBSel_i, alu_i, pc_i, funct3_i, addr_lsb_i,
               mem_rvalid_i, mem_rdata_i,
        input  ready_o, AddrD_o, DataD_o, RegWEn_o, pending_o, pending_rd_o
    );

endinterface

// File: rtl/riscv_load_align.sv
// Combinational load alignment: picks the addressed byte/half of the raw
// word and sign- or zero-extends it according to funct3.
module riscv_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lsb)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_addr_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];

    // LW and unused codes pass the word through untouched.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3Lb:    o_data = {{24{w_byte[7]}}, w_byte};
            F3Lbu:   o_data = {24'd0, w_byte};
            F3Lh:    o_data = {{16{w_half[15]}}, w_half};
            F3Lhu:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/riscv_wb_stage.sv
// Writeback stage: accepts one instruction at a time from MEM, waits for load
// data when needed and drives a single-cycle regfile write in COMMIT.
module riscv_wb_stage
    import riscv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    riscv_wb_stage_if.slave  wb
);

    wb_state_e   r_state;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lsb;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        r_regwen;
    logic        r_pending;
    logic [4:0]  r_pending_rd;

    logic        w_ready;
    logic        w_accept;
    logic        w_is_load;
    logic [31:0] w_exec_data;
    logic [31:0] w_load_data;

    assign w_ready   = rst_ni && (r_state != StWaitMem);
    assign w_accept  = wb.valid_i && w_ready;
    assign w_is_load = (wb.WBSel_i == WbMem);

    // WbRsvd falls through to the ALU result.
    always_comb begin
        w_exec_data = wb.alu_i;
        if (wb.WBSel_i == WbPc4) begin
            w_exec_data = pc_plus4(wb.pc_i);
        end
    end

    riscv_load_align u_load_align (
        .i_rdata    (wb.mem_rdata_i),
        .i_funct3   (r_funct3),
        .i_addr_lsb (r_lsb),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_rd         <= 5'd0;
            r_wen        <= 1'b0;
            r_funct3     <= 3'd0;
            r_lsb        <= 2'd0;
            r_addr       <= 5'd0;
            r_data       <= 32'd0;
            r_regwen     <= 1'b0;
            r_pending    <= 1'b0;
            r_pending_rd <= 5'd0;
        end else begin
            r_regwen <= 1'b0;
            case (r_state)
                StIdle, StCommit: begin
                    if (w_accept && w_is_load) begin
                        r_state      <= StWaitMem;
                        r_rd         <= wb.rd_i;
                        r_wen        <= wb.RegWEn_i;
                        r_funct3     <= wb.funct3_i;
                        r_lsb        <= wb.addr_lsb_i;
                        r_pending    <= 1'b1;
                        r_pending_rd <= wb.RegWEn_i ? wb.rd_i : 5'd0;
                    end else if (w_accept) begin
                        r_state  <= StCommit;
                        r_addr   <= wb.rd_i;
                        r_data   <= w_exec_data;
                        r_regwen <= wb.RegWEn_i && (wb.rd_i != 5'd0);
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWaitMem: begin
                    if (wb.mem_rvalid_i) begin
                        r_state      <= StCommit;
                        r_addr       <= r_rd;
                        r_data       <= w_load_data;
                        r_regwen     <= r_wen && (r_rd != 5'd0);
                        r_pending    <= 1'b0;
                        r_pending_rd <= 5'd0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign wb.ready_o      = w_ready;
    assign wb.AddrD_o      = r_addr;
    assign wb.DataD_o      = r_data;
    assign wb.RegWEn_o     = r_regwen;
    assign wb.pending_o    = r_pending;
    assign wb.pending_rd_o = r_pending_rd;

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed, table-driven bench for riscv_wb_stage plus hand-written
// back-to-back and reset-during-load sequences.
module tb_riscv_wb_stage;

    logic clk_i;
    logic rst_ni;

    riscv_wb_stage_if wb_if ();

    riscv_wb_stage dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wb     (wb_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] rdata;
        logic        exp_wen;
        logic [31:0] exp_data;
        logic [4:0]  exp_prd;
    } vec_t;

    localparam int NVec = 14;
    vec_t vecs [NVec];

    int n_cmp;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_if.valid_i      = 1'b0;
        wb_if.rd_i         = 5'd0;
        wb_if.RegWEn_i     = 1'b0;
        wb_if.WBSel_i      = 2'b00;
        wb_if.alu_i        = 32'h0;
        wb_if.pc_i         = 32'h0;
        wb_if.funct3_i     = 3'd0;
        wb_if.addr_lsb_i   = 2'd0;
        wb_if.mem_rvalid_i = 1'b0;
        wb_if.mem_rdata_i  = 32'hAAAA_AAAA;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        chk({v.nm, ".ready"}, {31'd0, wb_if.ready_o}, 32'd1);
        wb_if.valid_i    = 1'b1;
        wb_if.rd_i       = v.rd;
        wb_if.RegWEn_i   = v.wen;
        wb_if.WBSel_i    = v.sel;
        wb_if.alu_i      = v.alu;
        wb_if.pc_i       = v.pc;
        wb_if.funct3_i   = v.f3;
        wb_if.addr_lsb_i = v.lsb;
        @(negedge clk_i);
        idle_inputs();
        if (v.sel == 2'b01) begin
            for (int i = 0; i < 3; i++) begin
                chk({v.nm, ".wait_ready"}, {31'd0, wb_if.ready_o}, 32'd0);
                chk({v.nm, ".pending"}, {31'd0, wb_if.pending_o}, 32'd1);
                chk({v.nm, ".pending_rd"}, {27'd0, wb_if.pending_rd_o}, {27'd0, v.exp_prd});
                chk({v.nm, ".wait_wen"}, {31'd0, wb_if.RegWEn_o}, 32'd0);
                if (i == 2) begin
                    wb_if.mem_rvalid_i = 1'b1;
                    wb_if.mem_rdata_i  = v.rdata;
                end
                @(negedge clk_i);
            end
            idle_inputs();
            chk({v.nm, ".pending_clr"}, {31'd0, wb_if.pending_o}, 32'd0);
        end
        chk({v.nm, ".wen"}, {31'd0, wb_if.RegWEn_o}, {31'd0, v.exp_wen});
        chk({v.nm, ".addr"}, {27'd0, wb_if.AddrD_o}, {27'd0, v.rd});
        chk({v.nm, ".data"}, wb_if.DataD_o, v.exp_data);
        @(negedge clk_i);
        chk({v.nm, ".wen_drop"}, {31'd0, wb_if.RegWEn_o}, 32'd0);
        chk({v.nm, ".data_hold"}, wb_if.DataD_o, v.exp_data);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //          nm      rd     wen  sel    alu           pc            f3    lsb   rdata         ewen ed            prd
        vecs[0]  = '{"alu",  5'd5,  1, 2'b00, 32'h12345678, 32'h0,        3'd0, 2'd0, 32'h0,        1, 32'h12345678, 5'd0};
        vecs[1]  = '{"lb",   5'd7,  1, 2'b01, 32'h0,        32'h0,        3'd0, 2'd3, 32'h80FF0000, 1, 32'hFFFFFF80, 5'd7};
        vecs[2]  = '{"lbu",  5'd7,  1, 2'b01, 32'h0,        32'h0,        3'd4, 2'd3, 32'h80FF0000, 1, 32'h00000080, 5'd7};
        vecs[3]  = '{"lhu",  5'd8,  1, 2'b01, 32'h0,        32'h0,        3'd5, 2'd2, 32'h80FF0000, 1, 32'h000080FF, 5'd8};
        vecs[4]  = '{"lh",   5'd9,  1, 2'b01, 32'h0,        32'h0,        3'd1, 2'd2, 32'h80FF0000, 1, 32'hFFFF80FF, 5'd9};
        vecs[5]  = '{"lw",   5'd10, 1, 2'b01, 32'h0,        32'h0,        3'd2, 2'd0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 5'd10};
        vecs[6]  = '{"lb1",  5'd11, 1, 2'b01, 32'h0,        32'h0,        3'd0, 2'd1, 32'h00007F00, 1, 32'h0000007F, 5'd11};
        vecs[7]  = '{"jalw", 5'd1,  1, 2'b10, 32'h0,        32'hFFFFFFFC, 3'd0, 2'd0, 32'h0,        1, 32'h00000000, 5'd0};
        vecs[8]  = '{"jal",  5'd2,  1, 2'b10, 32'h0,        32'h00001000, 3'd0, 2'd0, 32'h0,        1, 32'h00001004, 5'd0};
        vecs[9]  = '{"x0",   5'd0,  1, 2'b00, 32'hDEADBEEF, 32'h0,        3'd0, 2'd0, 32'h0,        0, 32'hDEADBEEF, 5'd0};
        vecs[10] = '{"sel3", 5'd3,  1, 2'b11, 32'h00000055, 32'h00000100, 3'd0, 2'd0, 32'h0,        1, 32'h00000055, 5'd0};
        vecs[11] = '{"nowe", 5'd4,  0, 2'b00, 32'h00000077, 32'h0,        3'd0, 2'd0, 32'h0,        0, 32'h00000077, 5'd0};
        vecs[12] = '{"ldnw", 5'd12, 0, 2'b01, 32'h0,        32'h0,        3'd2, 2'd0, 32'h00000011, 0, 32'h00000011, 5'd0};
        vecs[13] = '{"ld3",  5'd13, 1, 2'b01, 32'h0,        32'h0,        3'd3, 2'd1, 32'h87654321, 1, 32'h87654321, 5'd13};

        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.ready", {31'd0, wb_if.ready_o}, 32'd0);
        chk("rst.wen", {31'd0, wb_if.RegWEn_o}, 32'd0);
        chk("rst.addr", {27'd0, wb_if.AddrD_o}, 32'd0);
        chk("rst.data", wb_if.DataD_o, 32'd0);
        chk("rst.pending", {31'd0, wb_if.pending_o}, 32'd0);
        chk("rst.pending_rd", {27'd0, wb_if.pending_rd_o}, 32'd0);
        rst_ni = 1'b1;

        // Stray load response in IDLE must not produce a write.
        @(negedge clk_i);
        wb_if.mem_rvalid_i = 1'b1;
        wb_if.mem_rdata_i  = 32'h12121212;
        @(negedge clk_i);
        idle_inputs();
        chk("idle_rvalid.wen", {31'd0, wb_if.RegWEn_o}, 32'd0);
        chk("idle_rvalid.ready", {31'd0, wb_if.ready_o}, 32'd1);

        for (int i = 0; i < NVec; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back ALU ops, rd/alu 1..4.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_i);
            if (i > 1) begin
                chk("b2b.wen", {31'd0, wb_if.RegWEn_o}, 32'd1);
                chk("b2b.addr", {27'd0, wb_if.AddrD_o}, i - 1);
                chk("b2b.data", wb_if.DataD_o, i - 1);
            end
            if (i <= 4) begin
                chk("b2b.ready", {31'd0, wb_if.ready_o}, 32'd1);
                wb_if.valid_i  = 1'b1;
                wb_if.rd_i     = 5'(i);
                wb_if.RegWEn_i = 1'b1;
                wb_if.WBSel_i  = 2'b00;
                wb_if.alu_i    = 32'(i);
            end else begin
                idle_inputs();
            end
        end
        @(negedge clk_i);
        chk("b2b.wen_drop", {31'd0, wb_if.RegWEn_o}, 32'd0);

        // Reset while a load is outstanding, then a late response.
        wb_if.valid_i  = 1'b1;
        wb_if.rd_i     = 5'd6;
        wb_if.RegWEn_i = 1'b1;
        wb_if.WBSel_i  = 2'b01;
        wb_if.funct3_i = 3'd2;
        @(negedge clk_i);
        idle_inputs();
        chk("rstld.pending", {31'd0, wb_if.pending_o}, 32'd1);
        chk("rstld.pending_rd", {27'd0, wb_if.pending_rd_o}, 32'd6);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rstld.ready_in_rst", {31'd0, wb_if.ready_o}, 32'd0);
        rst_ni = 1'b1;
        wb_if.mem_rvalid_i = 1'b1;
        wb_if.mem_rdata_i  = 32'h5A5A5A5A;
        @(negedge clk_i);
        idle_inputs();
        chk("rstld.wen", {31'd0, wb_if.RegWEn_o}, 32'd0);
        chk("rstld.pending_clr", {31'd0, wb_if.pending_o}, 32'd0);
        chk("rstld.ready", {31'd0, wb_if.ready_o}, 32'd1);
        @(negedge clk_i);
        chk("rstld.wen2", {31'd0, wb_if.RegWEn_o}, 32'd0);
        chk("rstld.data", wb_if.DataD_o, 32'd0);
        chk("rstld.addr", {27'd0, wb_if.AddrD_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
